// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents: FSM state enum, master-id constants, the default error read
// word, the latched request struct and the winner-selection helper.
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;

  // One picorv32-style request as captured at grant time.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  // Returns the id of the master to serve. With a single requester that
  // master wins; on a tie, fixed priority favours m0, otherwise the master
  // that was not served last wins. Result is don't-care with no requester.
  function automatic logic pick_winner(input logic v0, input logic v1,
                                       input logic last_id,
                                       input logic fixed_prio);
    logic win;
    if (v0 && v1) begin
      win = fixed_prio ? M0 : ~last_id;
    end else if (v1) begin
      win = M1;
    end else begin
      win = M0;
    end
    return win;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Per-transaction cycle counter that flags when an access has run too long.
// Latency: expire is a combinational decode of the registered count.
// Backpressure: none; count holds at the terminal value until cleared.
//
// Ports:
//   clock, reset : sole clock, synchronous active-high reset
//   clear        : zero the count (new transaction starting)
//   enable       : count this cycle (transaction in flight)
//   expire       : count has reached TIMEOUT-1; never set when TIMEOUT == 0
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      // Hold at the terminal value so expire stays asserted until cleared.
      count <= count + CW'(1);
    end
  end

  assign expire = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/mem_arbiter2.sv
// Two-master arbiter sharing one picorv32 native memory port (round-robin or fixed).
// Latency: request seen in IDLE at cycle N gives s_valid at N+1; master ready is
//   combinational with s_ready (or watchdog expiry); one IDLE cycle between accesses.
// Backpressure: a master holds valid until its ready pulse; a hung slave is cut off
//   by the watchdog, which returns ERR_RDATA and logs the failing access.
//
// Ports:
//   clock, reset                 : sole clock, synchronous active-high reset
//   m{0,1}_valid/addr/wdata/wstrb: master requests (wstrb == 0 means read)
//   m{0,1}_ready/rdata           : one-cycle completion, rdata is 0 unless ready
//   s_valid/addr/wdata/wstrb     : downstream request, fields latched at grant
//   s_ready/rdata                : downstream completion and read data
//   grant                        : one-hot current owner, 0 when idle
//   err_pulse                    : one cycle on a watchdog-terminated access
//   err_master/err_addr          : id and address of the last timeout (sticky)
//   err_count                    : saturating count of timeouts
module mem_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int unsigned  TIMEOUT        = 1024,
  parameter logic [31:0]  ERR_RDATA      = DEFAULT_ERR_RDATA,
  parameter bit           FIXED_PRIORITY = 1'b0
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        err_pulse,
  output logic        err_master,
  output logic [31:0] err_addr,
  output logic [7:0]  err_count
);

  arb_state_t  state;
  mem_req_t    lat_req;
  mem_req_t    m0_req;
  mem_req_t    m1_req;
  logic        last_grant;

  logic        in_grant;
  logic        start;
  logic        win_id;
  logic        owner;
  logic        expire;
  logic        done;
  logic        done_ok;
  logic        timed_out;
  logic [31:0] resp_data;

  assign m0_req = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign m1_req = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

  assign in_grant = (state == GRANT);
  assign start    = (state == IDLE) && (m0_valid || m1_valid);
  assign win_id   = pick_winner(m0_valid, m1_valid, last_grant, FIXED_PRIORITY);
  assign owner    = grant[1] ? M1 : M0;

  // s_ready has priority over an expiry landing in the same cycle.
  assign done      = in_grant && (s_ready || expire);
  assign timed_out = in_grant && !s_ready && expire;

  // A reset arriving alongside completion abandons the access: the FSM
  // returns to IDLE without ever showing the master a ready pulse.
  assign done_ok   = done && !reset;
  assign resp_data = s_ready ? s_rdata : ERR_RDATA;

  assign m0_ready  = done_ok && grant[0];
  assign m1_ready  = done_ok && grant[1];
  assign m0_rdata  = m0_ready ? resp_data : 32'h0;
  assign m1_rdata  = m1_ready ? resp_data : 32'h0;
  assign err_pulse = timed_out && !reset;

  assign s_addr  = lat_req.addr;
  assign s_wdata = lat_req.wdata;
  assign s_wstrb = lat_req.wstrb;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (start),
    .enable (in_grant),
    .expire (expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      s_valid    <= 1'b0;
      grant      <= 2'b00;
      lat_req    <= '0;
      last_grant <= M1;          // so m0 wins the first tie
      err_master <= 1'b0;
      err_addr   <= 32'h0;
      err_count  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          // s_ready is deliberately ignored here.
          if (start) begin
            lat_req <= (win_id == M1) ? m1_req : m0_req;
            grant   <= (win_id == M1) ? 2'b10 : 2'b01;
            s_valid <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          // Master valid is not consulted: a master dropping valid mid-access
          // still gets its completion once the slave finishes.
          if (done) begin
            state      <= IDLE;
            s_valid    <= 1'b0;
            grant      <= 2'b00;
            last_grant <= owner;
            if (timed_out) begin
              err_master <= owner;
              err_addr   <= lat_req.addr;
              if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
